weight_bank_ctrl: RTL and testbench

Ping-pong weight-bank controller for the TDNN DPD generator. Owns the single-port weight memory. It arbitrates each cycle between generator weight reads and streamed weight-image writes from the GAN training path. Complete images land in the shadow bank; the generator's bank select is switched atomically only between samples, so no sample ever mixes weights from two banks.

---
 rtl/dpd_pkg.sv | 27 ++
 rtl/wbank_img_checker.sv | 61 ++++++
 rtl/weight_bank_ctrl.sv | 145 ++++++++++++++
 tb/tb_weight_bank_ctrl.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dpd_pkg.sv
// Shared constants and state encoding for the TDNN DPD generator weight path.
// The WBANK_CHKSUM_EN macro adds one trailing checksum word to each weight image.
package dpd_pkg;

  localparam int WEIGHT_WIDTH = 16;
  localparam int BANK_SIZE    = 1170;

  // Offsets of the FC weights and biases within one bank image.
  localparam int FC_W_OFFSET  = 1040;
  localparam int BIAS_OFFSET  = 1160;

  typedef enum logic [1:0] {
    WB_RECV  = 2'd0,
    WB_DRAIN = 2'd1,
    WB_PEND  = 2'd2
  } wb_state_t;

  // Number of words in a streamed image, including the optional checksum word.
  function automatic int img_len(input int bank_size);
`ifdef WBANK_CHKSUM_EN
    return bank_size + 1;
`else
    return bank_size;
`endif
  endfunction

endpackage

// File: rtl/wbank_img_checker.sv
// Counts words of an incoming weight image and flags completion, length and checksum errors.
// The checksum path exists only when WBANK_CHKSUM_EN is defined.
module wbank_img_checker
  import dpd_pkg::*;
#(
  parameter int WEIGHT_WIDTH = 16,
  parameter int BANK_SIZE    = 1170,
  parameter int CNT_W        = $clog2(img_len(BANK_SIZE) + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             accept,
  input  logic             last,
`ifdef WBANK_CHKSUM_EN
  input  logic [WEIGHT_WIDTH-1:0] data,
`endif
  output logic [CNT_W-1:0] wr_cnt,
  output logic             done,
  output logic             len_err,
  output logic             chk_err
);

  localparam int IMG_LEN = img_len(BANK_SIZE);

  logic [CNT_W-1:0] wr_cnt_reg;
  logic             at_end;
  logic             sum_ok;

  assign at_end = (wr_cnt_reg == CNT_W'(IMG_LEN - 1));
  assign wr_cnt = wr_cnt_reg;

`ifdef WBANK_CHKSUM_EN
  logic [15:0] sum_reg;
  logic [15:0] sum_next;

  assign sum_next = sum_reg + 16'(data);
  assign sum_ok   = (sum_next == 16'd0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      sum_reg <= '0;
    else if (accept)
      sum_reg <= (last | at_end) ? 16'd0 : sum_next;
  end
`else
  assign sum_ok = 1'b1;
`endif

  // A length error is either an early last or a missing last on the final word.
  assign done    = accept & last & at_end & sum_ok;
  assign chk_err = accept & last & at_end & ~sum_ok;
  assign len_err = accept & (last ^ at_end);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      wr_cnt_reg <= '0;
    else if (accept)
      wr_cnt_reg <= (last | at_end) ? '0 : wr_cnt_reg + CNT_W'(1);
  end

endmodule

// File: rtl/weight_bank_ctrl.sv
// Ping-pong weight-bank controller: arbitrates the single-port weight memory between generator
// reads and image writes, and swaps banks only between samples. WBANK_CHKSUM_EN enables checksums.
module weight_bank_ctrl
  import dpd_pkg::*;
#(
  parameter int WEIGHT_WIDTH = dpd_pkg::WEIGHT_WIDTH,
  parameter int ADDR_WIDTH   = 16,
  parameter int BANK_SIZE    = dpd_pkg::BANK_SIZE,
  parameter int NUM_BANKS    = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    smp_valid,
  output logic                    smp_ready,
  output logic                    gen_in_valid,
  input  logic                    gen_busy,
  input  logic [ADDR_WIDTH-1:0]   gen_weight_addr,
  output logic [WEIGHT_WIDTH-1:0] gen_weight_data,
  output logic [1:0]              bank_sel,
  input  logic                    upd_valid,
  output logic                    upd_ready,
  input  logic [WEIGHT_WIDTH-1:0] upd_data,
  input  logic                    upd_last,
  output logic [ADDR_WIDTH-1:0]   mem_addr,
  output logic                    mem_we,
  output logic [WEIGHT_WIDTH-1:0] mem_wdata,
  input  logic [WEIGHT_WIDTH-1:0] mem_rdata,
  input  logic                    err_clr,
  output logic                    err_len,
  output logic                    err_chk,
  output logic [15:0]             swap_cnt
);

  localparam int IMG_LEN = img_len(BANK_SIZE);
  localparam int CNT_W   = $clog2(IMG_LEN + 1);

  wb_state_t        state_reg;
  logic [1:0]       bank_sel_reg;
  logic [15:0]      swap_cnt_reg;
  logic             err_len_reg;
  logic             err_chk_reg;

  logic [1:0]            shadow;
  logic                  accept;
  logic                  recv_acc;
  logic                  in_image;
  logic [CNT_W-1:0]      wr_cnt;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic                  done;
  logic                  len_err;
  logic                  chk_err;

  assign shadow = (bank_sel_reg == 2'(NUM_BANKS - 1)) ? 2'd0 : bank_sel_reg + 2'd1;

  always_comb begin
    upd_ready = 1'b0;
    case (state_reg)
      WB_RECV:  upd_ready = ~gen_busy;
      WB_DRAIN: upd_ready = 1'b1;
      default:  upd_ready = 1'b0;
    endcase
  end

  assign accept   = upd_valid & upd_ready;
  assign recv_acc = accept & (state_reg == WB_RECV);

  wbank_img_checker #(
    .WEIGHT_WIDTH (WEIGHT_WIDTH),
    .BANK_SIZE    (BANK_SIZE),
    .CNT_W        (CNT_W)
  ) u_checker (
    .clk     (clk),
    .rst_n   (rst_n),
    .accept  (recv_acc),
    .last    (upd_last),
`ifdef WBANK_CHKSUM_EN
    .data    (upd_data),
`endif
    .wr_cnt  (wr_cnt),
    .done    (done),
    .len_err (len_err),
    .chk_err (chk_err)
  );

  // The trailing checksum word (if any) sits past BANK_SIZE and is never written.
  assign in_image = (wr_cnt < CNT_W'(BANK_SIZE));
  assign wr_addr  = ADDR_WIDTH'(shadow) * ADDR_WIDTH'(BANK_SIZE) + ADDR_WIDTH'(wr_cnt);

  // recv_acc already implies an idle generator, so reads always win the port.
  assign mem_we          = recv_acc & in_image;
  assign mem_addr        = gen_busy ? gen_weight_addr : wr_addr;
  assign mem_wdata       = upd_data;
  assign gen_weight_data = mem_rdata;

  assign smp_ready    = ~gen_busy & (state_reg != WB_PEND);
  assign gen_in_valid = smp_valid & smp_ready;

  assign bank_sel = bank_sel_reg;
  assign swap_cnt = swap_cnt_reg;
  assign err_len  = err_len_reg;
  assign err_chk  = err_chk_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= WB_RECV;
      bank_sel_reg <= 2'd0;
      swap_cnt_reg <= 16'd0;
      err_len_reg  <= 1'b0;
      err_chk_reg  <= 1'b0;
    end else begin
      // An error event in the clear cycle keeps the flag set.
      if (len_err)
        err_len_reg <= 1'b1;
      else if (err_clr)
        err_len_reg <= 1'b0;

      if (chk_err)
        err_chk_reg <= 1'b1;
      else if (err_clr)
        err_chk_reg <= 1'b0;

      case (state_reg)
        WB_RECV: begin
          if (done)
            state_reg <= WB_PEND;
          else if (len_err && !upd_last)
            state_reg <= WB_DRAIN;
        end
        WB_DRAIN: begin
          if (accept && upd_last)
            state_reg <= WB_RECV;
        end
        WB_PEND: begin
          if (!gen_busy) begin
            bank_sel_reg <= shadow;
            swap_cnt_reg <= swap_cnt_reg + 16'd1;
            state_reg    <= WB_RECV;
          end
        end
        default: state_reg <= WB_RECV;
      endcase
    end
  end

endmodule

// File: tb/tb_weight_bank_ctrl.sv
// Self-checking bench for weight_bank_ctrl with BANK_SIZE=8, NUM_BANKS=2.
// Define WBANK_CHKSUM_EN to run the checksum sequences instead of the default ones.
module tb_weight_bank_ctrl;

  localparam int AW = 16;
  localparam int WW = 16;
  localparam int BS = 8;
  localparam int NB = 2;
  localparam int NV = 50;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n;
  logic          smp_valid;
  logic          smp_ready;
  logic          gen_in_valid;
  logic          gen_busy;
  logic [AW-1:0] gen_weight_addr;
  logic [WW-1:0] gen_weight_data;
  logic [1:0]    bank_sel;
  logic          upd_valid;
  logic          upd_ready;
  logic [WW-1:0] upd_data;
  logic          upd_last;
  logic [AW-1:0] mem_addr;
  logic          mem_we;
  logic [WW-1:0] mem_wdata;
  logic [WW-1:0] mem_rdata;
  logic          err_clr;
  logic          err_len;
  logic          err_chk;
  logic [15:0]   swap_cnt;

  weight_bank_ctrl #(
    .WEIGHT_WIDTH (WW),
    .ADDR_WIDTH   (AW),
    .BANK_SIZE    (BS),
    .NUM_BANKS    (NB)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .smp_valid       (smp_valid),
    .smp_ready       (smp_ready),
    .gen_in_valid    (gen_in_valid),
    .gen_busy        (gen_busy),
    .gen_weight_addr (gen_weight_addr),
    .gen_weight_data (gen_weight_data),
    .bank_sel        (bank_sel),
    .upd_valid       (upd_valid),
    .upd_ready       (upd_ready),
    .upd_data        (upd_data),
    .upd_last        (upd_last),
    .mem_addr        (mem_addr),
    .mem_we          (mem_we),
    .mem_wdata       (mem_wdata),
    .mem_rdata       (mem_rdata),
    .err_clr         (err_clr),
    .err_len         (err_len),
    .err_chk         (err_chk),
    .swap_cnt        (swap_cnt)
  );

  // Single-port memory with one-cycle registered read.
  logic [WW-1:0] mem_model [0:31];
  always @(posedge clk) begin
    if (mem_we)
      mem_model[mem_addr[4:0]] <= mem_wdata;
    mem_rdata <= mem_model[mem_addr[4:0]];
  end

  typedef struct {
    logic [AW-1:0] addr;
    logic [WW-1:0] data;
  } wr_t;

  typedef struct {
    logic          busy;
    logic          sv;
    logic          valid;
    logic          last;
    logic [WW-1:0] data;
    logic [AW-1:0] ga;
    logic          ur;
    logic          we;
    logic [AW-1:0] addr;
    logic          sr;
    logic          iv;
    logic [1:0]    bs;
    logic [15:0]   sc;
  } vec_t;

  wr_t  sb_q[$];
  vec_t tbl[NV];
  int   n_chk = 0;
  int   n_err = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", nm, act, exp);
    end
  endtask

  task automatic sb_push(input logic [AW-1:0] a, input logic [WW-1:0] d);
    wr_t e;
    e.addr = a;
    e.data = d;
    sb_q.push_back(e);
  endtask

  // Compare an observed memory write against the oldest expected write.
  task automatic sb_pop(input string nm);
    wr_t e;
    if (mem_we) begin
      if (sb_q.size() == 0) begin
        n_chk++;
        n_err++;
        $display("FAIL %s_sb: write addr 0x%0h data 0x%0h, required no write", nm, mem_addr, mem_wdata);
      end else begin
        e = sb_q.pop_front();
        check({nm, "_addr"}, 32'(mem_addr), 32'(e.addr));
        check({nm, "_data"}, 32'(mem_wdata), 32'(e.data));
      end
    end
  endtask

  task automatic idle(input logic busy, input logic [AW-1:0] ga, input logic clr);
    @(negedge clk);
    smp_valid       = 1'b0;
    upd_valid       = 1'b0;
    upd_last        = 1'b0;
    gen_busy        = busy;
    gen_weight_addr = ga;
    err_clr         = clr;
    #1;
  endtask

  task automatic send(input logic [WW-1:0] d, input logic last, input logic exp_we,
                      input logic [AW-1:0] exp_addr, input logic clr, input string nm);
    @(negedge clk);
    gen_busy        = 1'b0;
    smp_valid       = 1'b0;
    gen_weight_addr = '0;
    upd_valid       = 1'b1;
    upd_data        = d;
    upd_last        = last;
    err_clr         = clr;
    if (exp_we)
      sb_push(exp_addr, d);
    #1;
    $display("%s: word 0x%04h last=%0b we=%0b addr=0x%0h", nm, d, last, mem_we, mem_addr);
    check({nm, "_upd_ready"}, 32'(upd_ready), 32'(1'b1));
    check({nm, "_mem_we"}, 32'(mem_we), 32'(exp_we));
    sb_pop(nm);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    smp_valid = 1'b0;
    gen_busy = 1'b0;
    gen_weight_addr = '0;
    upd_valid = 1'b0;
    upd_data = '0;
    upd_last = 1'b0;
    err_clr = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rst_bank_sel", 32'(bank_sel), 32'd0);
    check("rst_swap_cnt", 32'(swap_cnt), 32'd0);
    check("rst_err_len", 32'(err_len), 32'd0);
    check("rst_err_chk", 32'(err_chk), 32'd0);
    check("rst_upd_ready", 32'(upd_ready), 32'd1);
    check("rst_smp_ready", 32'(smp_ready), 32'd1);
    check("rst_mem_we", 32'(mem_we), 32'd0);
  endtask

  initial begin
    // Rows 0-7: first image into bank 1; 8-9: swap; 10-29: busy hold; 30-37: image into bank 0;
    // 38-47: pending while busy; 48: swap cycle; 49: first sample on the new bank.
    for (int i = 0; i < NV; i++) begin
      tbl[i] = '{busy: 1'b0, sv: 1'b0, valid: 1'b0, last: 1'b0, data: '0, ga: '0,
                 ur: 1'b0, we: 1'b0, addr: '0, sr: 1'b0, iv: 1'b0, bs: 2'd0, sc: 16'd0};
    end
    for (int i = 0; i < 8; i++) begin
      tbl[i].valid = 1'b1; tbl[i].last = (i == 7); tbl[i].data = 16'(i + 1);
      tbl[i].ur = 1'b1; tbl[i].we = 1'b1; tbl[i].addr = 16'(8 + i); tbl[i].sr = 1'b1;
    end
    tbl[8].addr = 16'd8;
    tbl[9].ur = 1'b1; tbl[9].sr = 1'b1; tbl[9].bs = 2'd1; tbl[9].sc = 16'd1;
    for (int i = 10; i < 30; i++) begin
      tbl[i].busy = 1'b1; tbl[i].valid = 1'b1; tbl[i].data = 16'(16'hAA00 + i);
      tbl[i].ga = 16'(16'h0100 + i); tbl[i].addr = 16'(16'h0100 + i);
      tbl[i].bs = 2'd1; tbl[i].sc = 16'd1;
    end
    for (int i = 30; i < 38; i++) begin
      tbl[i].valid = 1'b1; tbl[i].last = (i == 37); tbl[i].data = 16'(16'h0010 + i - 30);
      tbl[i].ur = 1'b1; tbl[i].we = 1'b1; tbl[i].addr = 16'(i - 30); tbl[i].sr = 1'b1;
      tbl[i].bs = 2'd1; tbl[i].sc = 16'd1;
    end
    for (int i = 38; i < 48; i++) begin
      tbl[i].busy = 1'b1; tbl[i].ga = 16'(16'h0200 + i); tbl[i].addr = 16'(16'h0200 + i);
      tbl[i].bs = 2'd1; tbl[i].sc = 16'd1;
    end
    tbl[48].sv = 1'b1; tbl[48].addr = 16'd0; tbl[48].bs = 2'd1; tbl[48].sc = 16'd1;
    tbl[49].sv = 1'b1; tbl[49].ur = 1'b1; tbl[49].addr = 16'd8; tbl[49].sr = 1'b1;
    tbl[49].iv = 1'b1; tbl[49].bs = 2'd0; tbl[49].sc = 16'd2;

    rst_n = 1'b0;
    do_reset();

`ifdef WBANK_CHKSUM_EN
    for (int k = 0; k < 8; k++)
      send(16'h0001, 1'b0, 1'b1, 16'(8 + k), 1'b0, "ck_good");
    send(16'hFFF8, 1'b1, 1'b0, '0, 1'b0, "ck_good");
    idle(1'b0, '0, 1'b0);
    check("ck_good_pend_smp_ready", 32'(smp_ready), 32'd0);
    idle(1'b0, '0, 1'b0);
    check("ck_good_bank_sel", 32'(bank_sel), 32'd1);
    check("ck_good_err_chk", 32'(err_chk), 32'd0);
    for (int k = 0; k < 8; k++)
      send(16'h0001, 1'b0, 1'b1, 16'(k), 1'b0, "ck_bad");
    send(16'hFFF7, 1'b1, 1'b0, '0, 1'b0, "ck_bad");
    idle(1'b0, '0, 1'b0);
    check("ck_bad_err_chk", 32'(err_chk), 32'd1);
    check("ck_bad_smp_ready", 32'(smp_ready), 32'd1);
    idle(1'b0, '0, 1'b0);
    check("ck_bad_bank_sel", 32'(bank_sel), 32'd1);
    check("ck_bad_swap_cnt", 32'(swap_cnt), 32'd1);
`else
    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      gen_busy        = tbl[i].busy;
      smp_valid       = tbl[i].sv;
      upd_valid       = tbl[i].valid;
      upd_last        = tbl[i].last;
      upd_data        = tbl[i].data;
      gen_weight_addr = tbl[i].ga;
      err_clr         = 1'b0;
      if (tbl[i].we)
        sb_push(tbl[i].addr, tbl[i].data);
      #1;
      $display("v%0d: busy=%0b upd_ready=%0b we=%0b addr=0x%0h smp_ready=%0b bank_sel=%0d swap_cnt=%0d",
               i, gen_busy, upd_ready, mem_we, mem_addr, smp_ready, bank_sel, swap_cnt);
      check($sformatf("v%0d_upd_ready", i), 32'(upd_ready), 32'(tbl[i].ur));
      check($sformatf("v%0d_mem_we", i), 32'(mem_we), 32'(tbl[i].we));
      check($sformatf("v%0d_mem_addr", i), 32'(mem_addr), 32'(tbl[i].addr));
      check($sformatf("v%0d_smp_ready", i), 32'(smp_ready), 32'(tbl[i].sr));
      check($sformatf("v%0d_gen_in_valid", i), 32'(gen_in_valid), 32'(tbl[i].iv));
      check($sformatf("v%0d_bank_sel", i), 32'(bank_sel), 32'(tbl[i].bs));
      check($sformatf("v%0d_swap_cnt", i), 32'(swap_cnt), 32'(tbl[i].sc));
      sb_pop($sformatf("v%0d", i));
    end

    // Generator read of bank 1 word 1 written by the first image.
    idle(1'b1, 16'd9, 1'b0);
    idle(1'b0, 16'd0, 1'b0);
    check("rd_gen_weight_data", 32'(gen_weight_data), 32'h0002);

    // Short image: last on the 5th word.
    for (int k = 0; k < 5; k++)
      send(16'(16'h0030 + k), (k == 4), 1'b1, 16'(8 + k), 1'b0, "short");
    idle(1'b0, '0, 1'b0);
    check("short_err_len", 32'(err_len), 32'd1);
    check("short_smp_ready", 32'(smp_ready), 32'd1);
    idle(1'b0, '0, 1'b0);
    check("short_bank_sel", 32'(bank_sel), 32'd0);
    check("short_swap_cnt", 32'(swap_cnt), 32'd2);

    for (int k = 0; k < 8; k++)
      send(16'(16'h0040 + k), (k == 7), 1'b1, 16'(8 + k), 1'b0, "recover");
    idle(1'b0, '0, 1'b0);
    check("recover_pend_smp_ready", 32'(smp_ready), 32'd0);
    idle(1'b0, '0, 1'b0);
    check("recover_bank_sel", 32'(bank_sel), 32'd1);
    check("recover_swap_cnt", 32'(swap_cnt), 32'd3);
    check("recover_err_len_kept", 32'(err_len), 32'd1);
    idle(1'b0, '0, 1'b1);
    idle(1'b0, '0, 1'b0);
    check("clr_err_len", 32'(err_len), 32'd0);

    // Long image: 10 words; the 8th raises err_len even with err_clr in the same cycle.
    for (int k = 0; k < 10; k++) begin
      send(16'(16'h0050 + k), (k == 9), (k < 8), 16'(k), (k == 7), "long");
      if (k == 8)
        check("long_err_len", 32'(err_len), 32'd1);
    end
    idle(1'b1, 16'h0300, 1'b0);
    check("long_recv_upd_ready", 32'(upd_ready), 32'd0);
    check("long_err_len_kept", 32'(err_len), 32'd1);
    check("long_bank_sel", 32'(bank_sel), 32'd1);
    check("long_swap_cnt", 32'(swap_cnt), 32'd3);
`endif

    idle(1'b0, '0, 1'b0);
    check("sb_leftover", 32'(sb_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
